// File: rtl/shreg_pkg.sv
// Shared types for the shift_reg_burst block: idle ops, FSM states and burst direction codes.
package shreg_pkg;

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeShr  = 2'b01,
    ModeShl  = 2'b10,
    ModeLoad = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_t;

  localparam logic DirRight = 1'b0;
  localparam logic DirLeft  = 1'b1;

endpackage

// File: rtl/shift_reg_burst_if.sv
// Control/data bundle of shift_reg_burst; master drives ops and data, slave is the register.
interface shift_reg_burst_if #(
  parameter int unsigned WIDTH = 8
);
  import shreg_pkg::*;

  mode_t            mode;
  logic             start;
  logic             dir;
  logic             abort;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output mode, start, dir, abort, din, sin,
    input  dout, sout, busy, done
  );

  modport slave (
    input  mode, start, dir, abort, din, sin,
    output dout, sout, busy, done
  );

endinterface

// File: rtl/shreg_bit_counter.sv
// Burst shift counter: clr restarts at zero, inc advances; last flags the increment that reaches MAX.
module shreg_bit_counter #(
  parameter  int unsigned MAX   = 8,
  localparam int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign last = inc && (cnt_q == CNT_W'(MAX - 1));

endmodule

// File: rtl/shift_reg_burst.sv
// Universal shift register with a start-triggered WIDTH-shift serialise/deserialise burst.
// Define SHREG_ROTATE_EN to make burst shifts rotate instead of inserting sin.
module shift_reg_burst
  import shreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  shift_reg_burst_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [WIDTH-1:0] dout_q;
  logic             dir_q;
  logic             busy_q;
  logic             done_q;

  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt;
  logic             eff_dir;
  logic             sout;
  logic             burst_in;
  logic [WIDTH-1:0] burst_shift;

  // Saturating guard keeps cnt bounded even if the FSM were ever out of step.
  assign cnt_clr = (state_q == StIdle) && bus.start;
  assign cnt_inc = (state_q == StShift) && !bus.abort && (cnt != CNT_W'(WIDTH));

  shreg_bit_counter #(
    .MAX (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  always_comb begin
    eff_dir = dir_q;
    if (state_q == StIdle) begin
      eff_dir = (bus.mode == ModeShl) ? DirLeft : DirRight;
    end
  end

  assign sout = (eff_dir == DirLeft) ? dout_q[WIDTH-1] : dout_q[0];

`ifdef SHREG_ROTATE_EN
  assign burst_in = sout;
`else
  assign burst_in = bus.sin;
`endif

  assign burst_shift = (dir_q == DirLeft) ? {dout_q[WIDTH-2:0], burst_in}
                                          : {burst_in, dout_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      dout_q  <= '0;
      dir_q   <= DirRight;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            dout_q  <= bus.din;
            dir_q   <= bus.dir;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end else begin
            unique case (bus.mode)
              ModeHold: dout_q <= dout_q;
              ModeShr:  dout_q <= {bus.sin, dout_q[WIDTH-1:1]};
              ModeShl:  dout_q <= {dout_q[WIDTH-2:0], bus.sin};
              ModeLoad: dout_q <= bus.din;
            endcase
          end
        end
        StShift: begin
          // Abort beats the final shift: partial word kept, no done pulse.
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            dout_q <= burst_shift;
            if (cnt_last) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.dout = dout_q;
  assign bus.sout = sout;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_shift_reg_burst.sv
// Directed self-checking bench for shift_reg_burst (WIDTH=8); honours SHREG_ROTATE_EN.
module tb_shift_reg_burst;
  import shreg_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  shift_reg_burst_if #(.WIDTH(8)) bus ();

  shift_reg_burst #(
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] sout_exp;
    logic [7:0] sin_seq;
    logic [7:0] exp_word;
    int         n;
    logic       seen_done;

    checks = 0;
    errors = 0;
    reset     = 1'b1;
    bus.mode  = ModeHold;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.abort = 1'b0;
    bus.din   = 8'h00;
    bus.sin   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check8("rst_dout", bus.dout, 8'h00);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_done", bus.done, 1'b0);
    check1("rst_sout", bus.sout, 1'b0);

    // Reset asserted mid-burst takes effect without a clock edge
    bus.din   = 8'hFF;
    bus.dir   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check1("pre_rst_busy", bus.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check8("async_rst_dout", bus.dout, 8'h00);
    check1("async_rst_busy", bus.busy, 1'b0);
    check1("async_rst_done", bus.done, 1'b0);
    check1("async_rst_sout", bus.sout, 1'b0);
    tick();
    reset = 1'b0;

    // Idle ops
    bus.mode = ModeLoad;
    bus.din  = 8'hA5;
    tick();
    check8("idle_load", bus.dout, 8'hA5);
    bus.mode = ModeShr;
    bus.sin  = 1'b1;
    tick();
    check8("idle_shr", bus.dout, 8'hD2);
    bus.mode = ModeShl;
    bus.sin  = 1'b0;
    #1;
    check1("idle_shl_sout", bus.sout, 1'b1);
    tick();
    check8("idle_shl", bus.dout, 8'hA4);
    bus.mode = ModeHold;
    bus.sin  = 1'b1;
    tick();
    check8("idle_hold", bus.dout, 8'hA4);

`ifndef SHREG_ROTATE_EN
    // Burst right with sin insertion
    sout_exp  = 8'b1001_0110;
    sin_seq   = 8'b1000_1101;
    bus.din   = 8'h96;
    bus.dir   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check8("br_load", bus.dout, 8'h96);
    check1("br_busy", bus.busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check1($sformatf("br_sout%0d", i), bus.sout, sout_exp[i]);
      check1($sformatf("br_nodone%0d", i), bus.done, 1'b0);
      bus.sin = sin_seq[i];
      tick();
    end
    check8("br_final", bus.dout, 8'h8D);
    check1("br_done", bus.done, 1'b1);
    check1("br_busy_done", bus.busy, 1'b1);
    tick();
    check1("br_done_clr", bus.done, 1'b0);
    check1("br_busy_clr", bus.busy, 1'b0);
    check8("br_hold", bus.dout, 8'h8D);
`else
    // Burst left with rotation
    sout_exp  = 8'b0011_1100;
    bus.din   = 8'h3C;
    bus.dir   = 1'b1;
    bus.sin   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check1($sformatf("rot_sout%0d", i), bus.sout, sout_exp[7-i]);
      tick();
    end
    check8("rot_final", bus.dout, 8'h3C);
    check1("rot_done", bus.done, 1'b1);
    tick();
    check1("rot_done_clr", bus.done, 1'b0);
`endif

    // Abort after 3 shifts
    bus.din   = 8'hF0;
    bus.dir   = 1'b0;
    bus.sin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check8("abort_dout", bus.dout, 8'h1E);
    check1("abort_busy", bus.busy, 1'b0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen_done |= bus.done;
      tick();
    end
    check1("abort_no_done", seen_done, 1'b0);
    check8("abort_idle_hold", bus.dout, 8'h1E);

    // Start pulses during SHIFT and DONE are ignored
    bus.din   = 8'h5A;
    bus.dir   = 1'b1;
    bus.sin   = 1'b0;
    bus.start = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      bus.start = (n == 2);
      bus.din   = (n == 2) ? 8'hFF : 8'h5A;
      tick();
      n++;
      if (bus.done) break;
    end
    check8("burst_len", 8'(n), 8'd8);
`ifdef SHREG_ROTATE_EN
    exp_word = 8'h5A;
`else
    exp_word = 8'h00;
`endif
    check8("len_final", bus.dout, exp_word);
    bus.start = 1'b1;
    bus.din   = 8'h11;
    tick();
    bus.start = 1'b0;
    check1("done_start_busy", bus.busy, 1'b0);
    check1("done_start_done", bus.done, 1'b0);
    check8("done_start_dout", bus.dout, exp_word);
    tick();
    check1("done_start_idle", bus.busy, 1'b0);

    // Reset at shift 4
    bus.din   = 8'hC3;
    bus.dir   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check1("mid_busy", bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    check8("mid_rst_dout", bus.dout, 8'h00);
    check1("mid_rst_busy", bus.busy, 1'b0);
    tick();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen_done |= bus.done;
      tick();
    end
    check1("mid_rst_no_done", seen_done, 1'b0);
    check1("mid_rst_idle", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
